// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 constants, fetch state encoding and decode opcode fields
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] ILEN_BYTES = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  typedef enum logic [1:0] {S_FETCH, S_FULL, S_DROP} fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {instr,pc} buffer absorbing a response decode cannot take
module fetch_skid_buf
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_unload,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_full,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);
  logic            r_full;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  // occupancy: flush and unload empty it, load fills it
  always_ff @(posedge clk)
    if (!rst_n || i_flush || i_unload) r_full <= 1'b0;
    else if (i_load) r_full <= 1'b1;
  // payload is only meaningful while full, so it needs no reset
  always_ff @(posedge clk)
    if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  assign o_full  = r_full;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: PC owner issuing single-outstanding fetches into an IF/ID register
module ifetch_stage
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = rv32_pkg::RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);
  fetch_state_e    r_state;
  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] r_redir_q;
  logic            r_id_valid;
  logic [XLEN-1:0] r_id_instr;
  logic [XLEN-1:0] r_id_pc;
  logic            w_free;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_next;
  logic            w_skid_load;
  logic            w_skid_unload;
  logic            w_skid_full;
  logic [XLEN-1:0] w_skid_instr;
  logic [XLEN-1:0] w_skid_pc;
  // a bubble in IF/ID may always be overwritten, even under stall
  always_comb begin
    w_free        = !r_id_valid || !stall;
    w_tgt         = redirect_pc & ~32'h3;
    w_next        = r_req_addr + ILEN_BYTES;
    w_skid_load   = rst_n && !redirect_valid && r_state == S_FETCH && imem_ready && !w_free;
    w_skid_unload = rst_n && !redirect_valid && r_state == S_FULL && !stall;
  end
  assign imem_req  = rst_n && r_state != S_FULL;
  assign imem_addr = r_req_addr;
  assign id_valid  = r_id_valid;
  assign id_instr  = r_id_instr;
  assign id_pc     = r_id_pc;
  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_flush  (redirect_valid),
    .i_instr  (imem_rdata),
    .i_pc     (r_req_addr),
    .o_full   (w_skid_full),
    .o_instr  (w_skid_instr),
    .o_pc     (w_skid_pc)
  );
  // fetch FSM and IF/ID register; redirect overrides stall and any response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_req_addr <= RESET_PC;
      r_redir_q  <= RESET_PC;
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= RESET_PC;
    end else if (redirect_valid) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
      r_redir_q  <= w_tgt;
      if (r_state == S_FULL || imem_ready) begin
        r_req_addr <= w_tgt;
        r_state    <= S_FETCH;
      end else r_state <= S_DROP;
    end else begin
      unique case (r_state)
        S_FETCH:
          if (imem_ready && w_free) begin
            r_id_valid <= 1'b1;
            r_id_instr <= imem_rdata;
            r_id_pc    <= r_req_addr;
            r_req_addr <= w_next;
          end else if (imem_ready) begin
            r_req_addr <= w_next;
            r_state    <= S_FULL;
          end else if (w_free) r_id_valid <= 1'b0;
        S_FULL:
          if (!stall) begin
            r_id_valid <= w_skid_full;
            r_id_instr <= w_skid_instr;
            r_id_pc    <= w_skid_pc;
            r_state    <= S_FETCH;
          end
        S_DROP: begin
          r_id_valid <= 1'b0;
          if (imem_ready) begin
            r_req_addr <= r_redir_q;
            r_state    <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
Instruction fetch stage that sits directly upstream of the decoder. It owns the PC and issues one-outstanding-request fetches to instruction memory over a req/ready handshake. It presents {instr, pc, valid} to decode through an IF/ID output register. It handles back-pressure from decode through a one-entry skid buffer, and handles redirects from branch/jump resolution, including discarding an in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, value driven on id_instr when invalid or flushed (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request; held until imem_ready
imem_addr  out  32  fetch address, word aligned, stable while imem_req=1
imem_rdata  in  32  instruction word, sampled when imem_req&imem_ready
imem_ready  in  1  response valid this cycle; may be same cycle as req (zero-wait)
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  32  redirect target; bits[1:0] ignored (forced 0)
stall  in  1  decode cannot accept; hold id_* outputs
id_valid  out  1  id_instr/id_pc hold a live instruction
id_instr  out  32  instruction to decode
id_pc  out  32  address of id_instr

Behaviour:
- Reset (rst_n=0 at edge): state=FETCH, req_addr=RESET_PC, skid empty, id_valid=0, id_instr=NOP_INSTR, id_pc=RESET_PC, redir_q=RESET_PC. imem_req=0 while rst_n=0, including combinationally. Reset mid-request abandons it; memory must tolerate req dropping under reset.
- imem_addr = req_addr register; [1:0] always 00. Address increment is +4 mod 2^32: 0xFFFF_FFFC -> 0x0000_0000.
- "Slot free" = !id_valid || !stall. Stall with id_valid=0 is ignored, because a bubble may be overwritten.
- States FETCH, FULL, DROP:
- FETCH: imem_req=1.
  - On ready & slot free: id_instr<=rdata, id_pc<=req_addr, id_valid<=1, req_addr<=req_addr+4; stay. Sustains 1 instr/cycle with zero-wait memory.
  - On ready & slot not free: skid<=rdata/req_addr, req_addr+=4 -> FULL.
  - No ready & slot free: id_valid<=0.
  - No ready & slot not free: hold outputs.
- FULL: imem_req=0; id_* held. When !stall: id_*<=skid, id_valid<=1, skid emptied -> FETCH; the next request goes out that same cycle.
- DROP: imem_req=1 at the stale req_addr (a request is never withdrawn). id_valid=0. On ready: rdata discarded, req_addr<=redir_q -> FETCH.
- Redirect (highest priority, beats stall):
  - Any state: id_valid<=0, id_instr<=NOP_INSTR, skid emptied.
  - FETCH & ready same cycle: response discarded, req_addr<=redirect_pc -> FETCH (first target request next cycle).
  - FETCH & !ready: redir_q<=redirect_pc -> DROP.
  - FULL: req_addr<=redirect_pc -> FETCH.
  - DROP: redir_q<=redirect_pc (latest wins). If ready same cycle, req_addr<=redirect_pc -> FETCH.
- Whenever id_valid=0 after a flush, id_instr=NOP_INSTR. Otherwise id_* change only on load events.
- Latency: redirect to first target instruction valid = 2 cycles with zero-wait memory.
- At most one outstanding request; id_pc is always the exact fetch address of id_instr.

Decomposition:
- Shared package rv32_pkg: XLEN=32, NOP_INSTR, default RESET_PC, fetch state encoding (FETCH/FULL/DROP), ILEN_BYTES=4. The decoder already consumes these opcode-field constants from the same package.
- One sub-module is natural: fetch_skid_buf, a one-entry {instr,pc} buffer with load/unload/flush and full flag.

Test Plan:
- Reset release, imem_ready tied 1, rdata=addr: cycle1 imem_addr=0x0. id_pc then steps 0x0,0x4,0x8,… one per cycle, id_instr=id_pc, id_valid stays 1.
- Stall held 3 cycles while response at 0x8 arrives: skid captures 0x8 and imem_req=0 for those cycles. id_pc stays 0x4, then reads 0x8, then 0xC with no loss or duplication.
- Memory latency 3 cycles; redirect_pc=0x100 asserted one cycle after request to 0x10: imem_addr stays 0x10 until ready, that data is dropped and id_valid=0. Next imem_addr=0x100; first id_pc=0x100.
- Redirect and stall in the same cycle with id_valid=1 in FULL: next cycle id_valid=0 and id_instr=0x13. imem_addr=0x200 (redirect_pc=0x202 forced aligned); skid contents are never emitted.
- Redirect to 0xFFFF_FFFC, ready=1: id_pc sequence 0xFFFF_FFFC then 0x0000_0000.
- rst_n low while in DROP: next cycle imem_req=0. After release, imem_addr=RESET_PC, id_valid=0, id_instr=0x13.
